// File: rtl/dmac_chn_sched_if.sv
// Bus between the channel register block / transfer engine and the channel scheduler.
// Request side: chntrg_all/chn_en/chn_pri are levels, and xfer_done/xfer_err are one-cycle pulses.
// Grant side: actv_chn_* is valid while actv_chn_vld=1, and chn_start/chn_cmplt/chn_err are one-cycle pulses.
interface dmac_chn_sched_if #(
  parameter int CHN_NUM   = 16,
  parameter int CHN_MUX_W = 4
);
  logic [CHN_NUM-1:0]   chntrg_all;
  logic [CHN_NUM-1:0]   chn_en;
  logic [CHN_NUM-1:0]   chn_pri;
  logic                 arb_mode;
  logic                 xfer_done;
  logic                 xfer_err;
  logic                 actv_chn_vld;
  logic [CHN_NUM-1:0]   actv_chn_cod;
  logic [CHN_MUX_W-1:0] actv_chn_num;
  logic                 chn_start;
  logic [CHN_NUM-1:0]   chn_cmplt;
  logic [CHN_NUM-1:0]   chn_err;

  modport master (
    output chntrg_all, chn_en, chn_pri, arb_mode, xfer_done, xfer_err,
    input  actv_chn_vld, actv_chn_cod, actv_chn_num, chn_start, chn_cmplt, chn_err
  );

  modport slave (
    input  chntrg_all, chn_en, chn_pri, arb_mode, xfer_done, xfer_err,
    output actv_chn_vld, actv_chn_cod, actv_chn_num, chn_start, chn_cmplt, chn_err
  );
endinterface

// File: rtl/dmac_chn_sched.sv
// DMA channel scheduler: two-level priority arbitration (fixed or round-robin) and
// holds one channel on the transfer engine until it reports done or error.
module dmac_chn_sched #(
  parameter int CHN_NUM   = 16,
  parameter int CHN_MUX_W = 4
) (
  input  logic                 hclk,
  input  logic                 hrst_n,
  dmac_chn_sched_if.slave      bus,
  output logic [1:0]           dbg_state_o,
  output logic [CHN_MUX_W-1:0] dbg_rr_ptr_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARB   = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  localparam logic [CHN_NUM-1:0]   ONE_V   = CHN_NUM'(1);
  localparam logic [CHN_MUX_W-1:0] RR_RST  = CHN_MUX_W'(CHN_NUM - 1);

  logic [1:0]           state_q, state_d;
  logic [CHN_MUX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                 vld_q, vld_d;
  logic [CHN_NUM-1:0]   cod_q, cod_d;
  logic [CHN_MUX_W-1:0] num_q, num_d;
  logic                 start_q, start_d;
  logic [CHN_NUM-1:0]   cmplt_q, cmplt_d;
  logic [CHN_NUM-1:0]   err_q, err_d;

  logic [CHN_NUM-1:0]   elig, hi, lo, sel;
  logic [CHN_NUM-1:0]   fix_gnt, above_msk, msk, rr_gnt, gnt;
  logic [CHN_MUX_W-1:0] gnt_num;

  always_comb begin
    elig = bus.chntrg_all & bus.chn_en;
    hi   = elig & bus.chn_pri;
    lo   = elig & ~bus.chn_pri;
    sel  = (hi != '0) ? hi : lo;

    fix_gnt = sel & (~sel + ONE_V);

    // Round-robin looks strictly above the last grant first, then wraps to the lowest.
    above_msk = {CHN_NUM{1'b1}} << rr_ptr_q;
    above_msk = above_msk << 1;
    msk       = sel & above_msk;
    rr_gnt    = (msk != '0) ? (msk & (~msk + ONE_V)) : fix_gnt;

    gnt = bus.arb_mode ? rr_gnt : fix_gnt;

    gnt_num = '0;
    for (int i = 0; i < CHN_NUM; i++) begin
      if (gnt[i]) gnt_num = gnt_num | CHN_MUX_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    vld_d    = vld_q;
    cod_d    = cod_q;
    num_d    = num_q;
    start_d  = 1'b0;
    cmplt_d  = '0;
    err_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (elig != '0) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (sel != '0) begin
          state_d = ST_START;
          vld_d   = 1'b1;
          cod_d   = gnt;
          num_d   = gnt_num;
          start_d = 1'b1;
          if (bus.arb_mode) rr_ptr_d = gnt_num;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // Error takes precedence when the engine reports both in the same cycle.
        if (bus.xfer_err || bus.xfer_done) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
          cod_d   = '0;
          num_d   = '0;
          if (bus.xfer_err) err_d   = cod_q;
          else              cmplt_d = cod_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        cod_d   = '0;
        num_d   = '0;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hrst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= RR_RST;
      vld_q    <= 1'b0;
      cod_q    <= '0;
      num_q    <= '0;
      start_q  <= 1'b0;
      cmplt_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      cod_q    <= cod_d;
      num_q    <= num_d;
      start_q  <= start_d;
      cmplt_q  <= cmplt_d;
      err_q    <= err_d;
    end
  end

  assign bus.actv_chn_vld = vld_q;
  assign bus.actv_chn_cod = cod_q;
  assign bus.actv_chn_num = num_q;
  assign bus.chn_start    = start_q;
  assign bus.chn_cmplt    = cmplt_q;
  assign bus.chn_err      = err_q;

  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_dmac_chn_sched.sv
// Bench for dmac_chn_sched: directed scenarios plus random transactions, with grants
// predicted by a search-based reference model and checked by a decoupled monitor.
module tb_dmac_chn_sched;

  localparam int SW = 21;  // {vld, cod, num}
  localparam int EW = 53;  // {vld, cod, num, err, cmplt}
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd3;

  logic       hclk;
  logic       hrst_n;
  logic [1:0] dbg_state;
  logic [3:0] dbg_rr;

  dmac_chn_sched_if #(.CHN_NUM(16), .CHN_MUX_W(4)) bus ();

  dmac_chn_sched #(.CHN_NUM(16), .CHN_MUX_W(4)) dut (
    .hclk         (hclk),
    .hrst_n       (hrst_n),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int errors = 0;
  int checks = 0;
  int model_rr = 15;
  bit mon_en = 1'b0;

  logic [SW-1:0] exp_start_q[$];
  logic [EW-1:0] exp_end_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Reference: pick the group, then search upward from the pointer (round-robin) or from 0.
  function automatic int ref_grant(input logic [15:0] trg, input logic [15:0] en,
                                   input logic [15:0] pri, input logic mode, input int rr);
    logic [15:0] elig;
    logic [15:0] sel;
    elig = trg & en;
    sel  = ((elig & pri) != 16'h0) ? (elig & pri) : (elig & ~pri);
    if (sel == 16'h0) return -1;
    if (mode) begin
      for (int i = rr + 1; i < 16; i++) if (sel[i]) return i;
    end
    for (int i = 0; i < 16; i++) if (sel[i]) return i;
    return -1;
  endfunction

  // monitor / scoreboard
  always @(negedge hclk) begin
    if (mon_en && hrst_n) begin
      if (bus.chn_start) begin
        if (exp_start_q.size() == 0) fail_now("unexpected_start");
        else check("start_grant", 64'({bus.actv_chn_vld, bus.actv_chn_cod, bus.actv_chn_num}),
                   64'(exp_start_q.pop_front()));
      end
      if ((bus.chn_cmplt != 16'h0) || (bus.chn_err != 16'h0)) begin
        if (exp_end_q.size() == 0) fail_now("unexpected_end_pulse");
        else check("end_pulse", 64'({bus.actv_chn_vld, bus.actv_chn_cod, bus.actv_chn_num,
                                     bus.chn_err, bus.chn_cmplt}), 64'(exp_end_q.pop_front()));
      end
    end
  end

  // driver: kind 0 = done, 1 = err, 2 = done+err
  task automatic run_xfer(input logic [15:0] trg, input logic [15:0] en, input logic [15:0] pri,
                          input logic mode, input int kind, input logic dis, input int bw,
                          input logic scr, input logic abort, input int want);
    int g;
    int lat;
    logic seen;
    logic [15:0] oh;
    @(negedge hclk);
    bus.chntrg_all = trg;
    bus.chn_en     = en;
    bus.chn_pri    = pri;
    bus.arb_mode   = mode;
    g = ref_grant(trg, en, pri, mode, model_rr);
    if (g < 0) begin
      repeat (6) @(negedge hclk);
      check("no_grant_idle", 64'(dbg_state), 64'(ST_IDLE));
      bus.chntrg_all = 16'h0;
      return;
    end
    oh = 16'h0;
    oh[g] = 1'b1;
    exp_start_q.push_back({1'b1, oh, 4'(g)});
    if (mode) model_rr = g;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 8) begin
      @(negedge hclk);
      lat++;
      seen = bus.chn_start;
    end
    if (!seen) begin
      fail_now("start_timeout");
      exp_start_q.delete();
      bus.chntrg_all = 16'h0;
      return;
    end
    check("grant_latency", 64'(lat), 64'd2);
    if (want >= 0) check("directed_num", 64'(bus.actv_chn_num), 64'(want));
    if (dis) bus.xfer_done = 1'b1;
    if (scr) begin
      bus.chntrg_all = 16'($urandom);
      bus.chn_en     = 16'($urandom);
      bus.chn_pri    = 16'($urandom);
      bus.arb_mode   = 1'($urandom_range(0, 1));
    end
    @(negedge hclk);
    bus.xfer_done = 1'b0;
    check("busy_hold", 64'({bus.actv_chn_vld, bus.actv_chn_cod}), 64'({1'b1, oh}));
    if (dis) begin
      check("done_in_start_state", 64'(dbg_state), 64'(ST_BUSY));
      check("done_in_start_cmplt", 64'(bus.chn_cmplt), 64'd0);
    end
    repeat (bw) @(negedge hclk);
    if (abort) begin
      hrst_n = 1'b0;
      @(negedge hclk);
      hrst_n = 1'b1;
      bus.chntrg_all = 16'h0;
      check("rst_outputs", 64'({bus.actv_chn_vld, bus.actv_chn_cod, bus.actv_chn_num,
                                bus.chn_start, bus.chn_cmplt, bus.chn_err}), 64'd0);
      check("rst_rr_ptr", 64'(dbg_rr), 64'd15);
      check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
      model_rr = 15;
      return;
    end
    exp_end_q.push_back({1'b0, 16'h0, 4'h0, (kind != 0) ? oh : 16'h0, (kind == 0) ? oh : 16'h0});
    bus.xfer_done = (kind != 1);
    bus.xfer_err  = (kind != 0);
    @(negedge hclk);
    bus.xfer_done  = 1'b0;
    bus.xfer_err   = 1'b0;
    bus.chntrg_all = 16'h0;
  endtask

  task automatic pulse_req();
    @(negedge hclk);
    bus.chntrg_all = 16'h0004;
    bus.chn_en     = 16'hFFFF;
    bus.chn_pri    = 16'h0;
    bus.arb_mode   = 1'b0;
    @(negedge hclk);
    bus.chntrg_all = 16'h0;
    check("pulse_in_arb", 64'(dbg_state), 64'(ST_ARB));
    repeat (6) @(negedge hclk);
    check("pulse_back_idle", 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hrst_n         = 1'b0;
    bus.chntrg_all = 16'h0;
    bus.chn_en     = 16'h0;
    bus.chn_pri    = 16'h0;
    bus.arb_mode   = 1'b0;
    bus.xfer_done  = 1'b0;
    bus.xfer_err   = 1'b0;
    repeat (3) @(negedge hclk);
    check("reset_outputs", 64'({bus.actv_chn_vld, bus.actv_chn_cod, bus.actv_chn_num,
                                bus.chn_start, bus.chn_cmplt, bus.chn_err}), 64'd0);
    check("reset_rr_ptr", 64'(dbg_rr), 64'd15);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    hrst_n = 1'b1;
    mon_en = 1'b1;

    // fixed priority, lowest index first
    run_xfer(16'h0028, 16'hFFFF, 16'h0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 3);
    run_xfer(16'h0020, 16'hFFFF, 16'h0, 1'b0, 0, 1'b0, 1, 1'b0, 1'b0, 5);
    // high group blocks low group
    run_xfer(16'h8001, 16'hFFFF, 16'h8000, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 15);
    run_xfer(16'h8001, 16'hFFFF, 16'h8000, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 15);
    run_xfer(16'h0001, 16'hFFFF, 16'h8000, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    // round-robin wrap-around: 1, 4, 7, 1, 4
    model_rr = 15;
    run_xfer(16'h0092, 16'hFFFF, 16'h0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1);
    run_xfer(16'h0092, 16'hFFFF, 16'h0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 4);
    run_xfer(16'h0092, 16'hFFFF, 16'h0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 7);
    run_xfer(16'h0092, 16'hFFFF, 16'h0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 1);
    run_xfer(16'h0092, 16'hFFFF, 16'h0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 4);
    // disabled request, then a one-cycle request
    run_xfer(16'h0004, 16'h0000, 16'h0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, -1);
    pulse_req();
    // done+err together on channel 2, with a done pulse during START
    run_xfer(16'h0004, 16'hFFFF, 16'h0, 1'b0, 2, 1'b1, 1, 1'b0, 1'b0, 2);
    // reset while busy on channel 6, then round-robin restarts from channel 0
    run_xfer(16'h0040, 16'hFFFF, 16'h0, 1'b1, 0, 1'b0, 2, 1'b0, 1'b1, 6);
    run_xfer(16'h0041, 16'hFFFF, 16'h0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [15:0] trg, en, pri;
      int k, r;
      trg = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom & $urandom);
      if ($urandom_range(0, 15) == 0) trg = 16'h0;
      en  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
      pri = 16'($urandom & $urandom & $urandom);
      r   = $urandom_range(0, 9);
      k   = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      run_xfer(trg, en, pri, 1'($urandom_range(0, 1)), k, ($urandom_range(0, 4) == 0),
               $urandom_range(0, 3), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), -1);
    end

    repeat (4) @(negedge hclk);
    check("start_queue_drained", 64'(exp_start_q.size()), 64'd0);
    check("end_queue_drained", 64'(exp_end_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
